decode_s1_pipe_reg: RTL and testbench

Pipeline register slice between decode stage 1 and decode stage 2. It captures the full stage-1 control bundle (size, operand selects, modrm/sib, imm/disp, ALU op, flags, stack op, segment override, pc, branch_taken) under a valid/ready handshake. It provides a registered `s1_ready` through a two-entry skid buffer and discards in-flight instructions on `flush`. Ordering is strictly FIFO; the payload is passed through unmodified.

---
 rtl/decode_s1_pipe_reg.sv | 172 +++++++++++++++++
 tb/tb_decode_s1_pipe_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_s1_pipe_reg.sv
// -----------------------------------------------------------------------------
// decode_s1_pipe_reg
//
// This is the pipeline register slice between decode stage 1 and decode stage 2.
// It carries the packed stage-1 control bundle without changing it. Entries
// leave in strict FIFO order. Every held entry is discarded on flush.
//
// Configuration macro: DECODE_S1_PIPE_SKID_EN
//   defined     - two entries: main M plus skid K. s1_ready is registered and
//                 has no combinational path from s2_ready.
//   not defined - a single entry M. s1_ready = ~M.valid | s2_ready, which is
//                 combinational.
//
// Parameters:
//   IADDRW - PC width.
//   PAYW   - bundle width, 130 + IADDRW.
//
// Ports:
//   clk        - rising-edge clock.
//   reset      - asynchronous reset, active low.
//   flush      - clears all held entries at the next edge. The s1 input is
//                ignored in that cycle.
//   s1_valid   - the upstream bundle is valid.
//   s1_ready   - upstream may transfer a bundle.
//   s1_bundle  - upstream payload.
//   s2_valid   - the head entry is valid.
//   s2_ready   - downstream accepts the head entry.
//   s2_bundle  - payload of the head entry.
//   occupancy  - number of held entries, registered.
// -----------------------------------------------------------------------------
module decode_s1_pipe_reg #(
    parameter int IADDRW = 32,
    parameter int PAYW   = 130 + IADDRW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [PAYW-1:0] s1_bundle,
    output logic            s2_valid,
    input  logic            s2_ready,
    output logic [PAYW-1:0] s2_bundle,
    output logic [1:0]      occupancy
);

    logic            m_valid_r;
    logic            m_valid_nxt_s;
    logic            m_load_s;
    logic [PAYW-1:0] m_data_r;
    logic [PAYW-1:0] m_din_s;
    logic [1:0]      occupancy_r;
    logic [1:0]      occ_nxt_s;
    logic            in_fire_s;
    logic            out_fire_s;

    assign out_fire_s = m_valid_r & s2_ready;
    assign s2_valid   = m_valid_r;
    assign s2_bundle  = m_data_r;
    assign occupancy  = occupancy_r;

`ifdef DECODE_S1_PIPE_SKID_EN
    logic            k_valid_r;
    logic            k_valid_nxt_s;
    logic            k_load_s;
    logic [PAYW-1:0] k_data_r;
    logic            s1_ready_r;

    // s1_ready_r always equals ~k_valid_r, so a full skid entry is what stops
    // the upstream stage.
    assign s1_ready  = s1_ready_r;
    assign in_fire_s = s1_valid & s1_ready_r & ~flush;
    assign occ_nxt_s = {1'b0, m_valid_nxt_s} + {1'b0, k_valid_nxt_s};

    // Next-state logic for the main and skid entries.
    always_comb begin
        m_valid_nxt_s = m_valid_r;
        k_valid_nxt_s = k_valid_r;
        m_load_s      = 1'b0;
        k_load_s      = 1'b0;
        m_din_s       = s1_bundle;
        if (flush) begin
            m_valid_nxt_s = 1'b0;
            k_valid_nxt_s = 1'b0;
        end else if (!m_valid_r) begin
            // K cannot be full while M is empty.
            if (in_fire_s) begin
                m_load_s      = 1'b1;
                m_valid_nxt_s = 1'b1;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else if (out_fire_s) begin
            if (k_valid_r) begin
                // Move the skid entry into M. in_fire_s is 0 here because s1_ready is low.
                m_load_s      = 1'b1;
                m_din_s       = k_data_r;
                k_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                m_load_s = 1'b1;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else if (in_fire_s) begin
            // M is stalled, so this beat goes into the skid entry.
            k_load_s      = 1'b1;
            k_valid_nxt_s = 1'b1;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end
    end

    // Skid valid flag and registered ready, both cleared by the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_valid_r  <= 1'b0;
            s1_ready_r <= 1'b1;
        end else begin
            k_valid_r  <= k_valid_nxt_s;
            s1_ready_r <= ~k_valid_nxt_s;
        end
    end

    // Skid payload. It loads only when enabled and has no reset.
    always_ff @(posedge clk) begin
        if (k_load_s) begin
            k_data_r <= s1_bundle;
        end
    end
`else
    // Single entry: M can accept a new beat in the same cycle that it drains.
    assign s1_ready  = ~m_valid_r | s2_ready;
    assign in_fire_s = s1_valid & s1_ready & ~flush;
    assign occ_nxt_s = {1'b0, m_valid_nxt_s};

    // Next-state logic for the single main entry.
    always_comb begin
        m_valid_nxt_s = m_valid_r;
        m_load_s      = 1'b0;
        m_din_s       = s1_bundle;
        if (flush) begin
            m_valid_nxt_s = 1'b0;
        end else if (in_fire_s) begin
            m_load_s      = 1'b1;
            m_valid_nxt_s = 1'b1;
        end else if (out_fire_s) begin
            m_valid_nxt_s = 1'b0;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end
    end
`endif

    // Main valid flag and occupancy count, both cleared by the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_r   <= 1'b0;
            occupancy_r <= 2'd0;
        end else begin
            m_valid_r   <= m_valid_nxt_s;
            occupancy_r <= occ_nxt_s;
        end
    end

    // Main payload. It loads only when enabled and has no reset.
    always_ff @(posedge clk) begin
        if (m_load_s) begin
            m_data_r <= m_din_s;
        end
    end

endmodule

// File: tb/tb_decode_s1_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_decode_s1_pipe_reg
//
// Directed self-checking bench for decode_s1_pipe_reg. The expected values that
// depend on the skid entry follow DECODE_S1_PIPE_SKID_EN.
// -----------------------------------------------------------------------------
module tb_decode_s1_pipe_reg;

    localparam int IADDRW = 32;
    localparam int PAYW   = 130 + IADDRW;
`ifdef DECODE_S1_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            flush;
    logic            s1_valid;
    logic            s1_ready;
    logic [PAYW-1:0] s1_bundle;
    logic            s2_valid;
    logic            s2_ready;
    logic [PAYW-1:0] s2_bundle;
    logic [1:0]      occupancy;

    int n_pass  = 0;
    int n_total = 0;

    decode_s1_pipe_reg #(.IADDRW(IADDRW), .PAYW(PAYW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_bundle (s1_bundle),
        .s2_valid  (s2_valid),
        .s2_ready  (s2_ready),
        .s2_bundle (s2_bundle),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a bundle from a pc. The pc goes in its own field and the
    // high-order fields carry patterns derived from it.
    function automatic logic [PAYW-1:0] mk(input logic [31:0] pc, input logic bt);
        logic [PAYW-1:0] b;
        b                  = '0;
        b[PAYW-1 -: 32]    = ~pc;
        b[PAYW-33 -: 48]   = {16'hC0DE, pc};
        b[IADDRW:1]        = pc;
        b[0]               = bt;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic [PAYW-1:0] obs, input logic [PAYW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

`ifdef DECODE_S1_PIPE_SKID_EN
    // Invariant: the skid entry is never valid while the main entry is empty.
    always @(negedge clk) begin
        if (reset) begin
            n_total++;
            assert (!dut.k_valid_r || dut.m_valid_r) n_pass++;
            else $error("FAIL skid_invariant: observed k=%0b m=%0b expected k->m", dut.k_valid_r, dut.m_valid_r);
        end
    end
`endif

    initial begin
        int  snd;
        int  rcv;
        bit  in_f;
        bit  out_f;

        reset = 1'b0; flush = 1'b0; s1_valid = 1'b0; s1_bundle = '0; s2_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s2_valid", 8'(s2_valid), 8'd0);
        chk("rst_s1_ready", 8'(s1_ready), 8'd1);
        chk("rst_occ", 8'(occupancy), 8'd0);
        reset = 1'b1;

        // Fill the slice, then assert reset in the middle of the stream.
        @(negedge clk);
        s1_valid = 1'b1; s1_bundle = mk(32'h10, 1'b0);
        #1 chk("fill_rdy0", 8'(s1_ready), 8'd1);
        @(negedge clk);
        s1_bundle = mk(32'h11, 1'b0);
        #1;
        chkb("fill_head", s2_bundle, mk(32'h10, 1'b0));
        chk("fill_occ1", 8'(occupancy), 8'd1);
        chk("fill_rdy1", 8'(s1_ready), SKID ? 8'd1 : 8'd0);
        @(negedge clk);
        #1;
        chk("fill_occ_full", 8'(occupancy), SKID ? 8'd2 : 8'd1);
        chk("fill_rdy_full", 8'(s1_ready), 8'd0);
        reset = 1'b0; s1_valid = 1'b0;
        #1;
        chk("async_rst_s2_valid", 8'(s2_valid), 8'd0);
        chk("async_rst_s1_ready", 8'(s1_ready), 8'd1);
        chk("async_rst_occ", 8'(occupancy), 8'd0);

        // After reset is released, the first bundle appears one cycle after it is accepted.
        @(negedge clk);
        reset = 1'b1; s1_valid = 1'b1; s1_bundle = mk(32'h52, 1'b1);
        #1 chk("a5_pre_valid", 8'(s2_valid), 8'd0);
        @(negedge clk);
        s1_valid = 1'b0;
        #1;
        chk("a5_valid", 8'(s2_valid), 8'd1);
        chk("a5_low_byte", s2_bundle[7:0], 8'hA5);
        chkb("a5_bundle", s2_bundle, mk(32'h52, 1'b1));
        chk("a5_occ", 8'(occupancy), 8'd1);
        s2_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("a5_drained_valid", 8'(s2_valid), 8'd0);
        chk("a5_drained_occ", 8'(occupancy), 8'd0);

        // Streaming: 16 bundles, one per cycle, with no bubbles.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                s1_valid = 1'b1; s1_bundle = mk(32'h1000 + 32'(i), 1'b0);
            end else begin
                s1_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                chk("stream_valid", 8'(s2_valid), 8'd1);
                chkb("stream_bundle", s2_bundle, mk(32'h1000 + 32'(i - 1), 1'b0));
                chk("stream_occ", 8'(occupancy), 8'd1);
            end
            chk("stream_rdy", 8'(s1_ready), 8'd1);
        end
        @(negedge clk);
        #1;
        chk("stream_end_valid", 8'(s2_valid), 8'd0);
        chk("stream_end_occ", 8'(occupancy), 8'd0);

        // Backpressure: pc 0x20..0x22 with s2_ready held low for the first four cycles.
        snd = 0; rcv = 0; in_f = 1'b0; out_f = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_f) snd++;
            if (out_f) rcv++;
            s2_ready  = (c >= 4);
            s1_valid  = (snd < 3);
            s1_bundle = mk(32'h20 + 32'(snd), 1'b0);
            #1;
            if (c == 3) begin
                chkb("bp_head", s2_bundle, mk(32'h20, 1'b0));
                chk("bp_occ_stall", 8'(occupancy), SKID ? 8'd2 : 8'd1);
                chk("bp_rdy_stall", 8'(s1_ready), 8'd0);
            end
            if (c == 4) begin
                chk("bp_rdy_release", 8'(s1_ready), SKID ? 8'd0 : 8'd1);
            end
            if (s2_valid && s2_ready) begin
                chkb("bp_order", s2_bundle, mk(32'h20 + 32'(rcv), 1'b0));
            end
            chk("bp_occ_bound", 8'(occupancy > (SKID ? 2'd2 : 2'd1)), 8'd0);
            in_f  = s1_valid & s1_ready;
            out_f = s2_valid & s2_ready;
        end
        chk("bp_sent", 8'(snd), 8'd3);
        chk("bp_received", 8'(rcv), 8'd3);
        chk("bp_end_occ", 8'(occupancy), 8'd0);

        // Flush a full slice while s1 presents pc 0x40.
        s2_ready = 1'b0;
        @(negedge clk);
        s1_valid = 1'b1; s1_bundle = mk(32'h30, 1'b0);
        @(negedge clk);
        s1_bundle = mk(32'h31, 1'b0);
        @(negedge clk);
        flush = 1'b1; s1_bundle = mk(32'h40, 1'b0);
        #1 chk("fl_pre_occ", 8'(occupancy), SKID ? 8'd2 : 8'd1);
        @(negedge clk);
        flush = 1'b0; s1_valid = 1'b0;
        #1;
        chk("fl_occ", 8'(occupancy), 8'd0);
        chk("fl_valid", 8'(s2_valid), 8'd0);
        chk("fl_rdy", 8'(s1_ready), 8'd1);
        s2_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1 chk("fl_no_0x40", 8'(s2_valid), 8'd0);
        end

        // Flush on an empty slice: the s1 beat presented during the flush is ignored.
        @(negedge clk);
        flush = 1'b1; s1_valid = 1'b1; s1_bundle = mk(32'h41, 1'b0);
        #1 chk("fle_rdy", 8'(s1_ready), 8'd1);
        @(negedge clk);
        flush = 1'b0; s1_valid = 1'b0;
        #1;
        chk("fle_occ", 8'(occupancy), 8'd0);
        chk("fle_valid", 8'(s2_valid), 8'd0);

        // Flush and drain in the same cycle, then pc 0x50 after one cycle.
        s2_ready = 1'b0;
        @(negedge clk);
        s1_valid = 1'b1; s1_bundle = mk(32'h48, 1'b0);
        @(negedge clk);
        s1_valid = 1'b0;
        #1;
        chk("col_pre_occ", 8'(occupancy), 8'd1);
        chkb("col_pre_head", s2_bundle, mk(32'h48, 1'b0));
        flush = 1'b1; s2_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; s1_valid = 1'b1; s1_bundle = mk(32'h50, 1'b0);
        #1;
        chk("col_occ", 8'(occupancy), 8'd0);
        chk("col_valid", 8'(s2_valid), 8'd0);
        @(negedge clk);
        s1_valid = 1'b0;
        #1;
        chk("col_0x50_valid", 8'(s2_valid), 8'd1);
        chkb("col_0x50_bundle", s2_bundle, mk(32'h50, 1'b0));
        chk("col_0x50_occ", 8'(occupancy), 8'd1);
        @(negedge clk);
        #1 chk("col_end_occ", 8'(occupancy), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
